sleep_wakeup_timer: RTL and testbench

APB-programmable wake-up scheduler for the core sleep controller. Arms a one-shot (optionally auto-reloading) cycle timer that starts counting when the core reports it is asleep. It drives the sleep controller's wake signal when the timeout expires or a masked external event arrives. Sits beside the sleep controller on the peripheral APB bus; `wakeup_o` feeds the controller's interrupt/event input.

---
 rtl/sleep_wakeup_timer.sv | 162 ++++++++++++++++
 tb/tb_sleep_wakeup_timer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sleep_wakeup_timer.sv
// APB wake-up scheduler: counts cycles while the core sleeps and raises a wake
// request on timeout or masked event. Define WAKEUP_TIMER_AUTORELOAD_EN for re-arm.
module sleep_wakeup_timer #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NUM_EVT        = 8
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [NUM_EVT-1:0]        event_i,
  input  logic                      core_sleeping_i,
  output logic                      wakeup_o,
  output logic                      timer_irq_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_COUNT = 2'd2,
    ST_FIRE  = 2'd3
  } state_e;

  localparam logic [2:0] IDX_CTRL    = 3'd0;
  localparam logic [2:0] IDX_COMPARE = 3'd1;
  localparam logic [2:0] IDX_COUNT   = 3'd2;
  localparam logic [2:0] IDX_STATUS  = 3'd3;
  localparam logic [2:0] IDX_MASK    = 3'd4;

  state_e               state_q, state_d;
  logic                 ctrl_enable, ctrl_irq_en, autoreload;
  logic [31:0]          compare_q, count_q, count_d, cmp_eff, rdata;
  logic [NUM_EVT-1:0]   evt_mask;
  logic                 fired_q, irq_q, wakeup_q;
  logic                 fire_set, en_clr, wakeup_d;
  logic                 wr_en, rd_en;
  logic                 wr_ctrl, wr_compare, wr_status, wr_mask;
  logic [2:0]           word_idx;
  logic                 unused_addr_bits;

  assign word_idx   = PADDR[4:2];
  assign wr_en      = PSEL & PENABLE & PWRITE;
  assign rd_en      = PSEL & PENABLE & ~PWRITE;
  assign wr_ctrl    = wr_en && (word_idx == IDX_CTRL);
  assign wr_compare = wr_en && (word_idx == IDX_COMPARE);
  assign wr_status  = wr_en && (word_idx == IDX_STATUS);
  assign wr_mask    = wr_en && (word_idx == IDX_MASK);

  assign unused_addr_bits = ^{PADDR[APB_ADDR_WIDTH-1:5], PADDR[1:0]};

  // A COMPARE write lands in the same cycle the comparison uses it.
  assign cmp_eff = wr_compare ? PWDATA : compare_q;

  // ---------------------------------------------------------------- state reg
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // --------------------------------------------------------------- next state
  // NOTE: default assignment first so no path leaves state_d unassigned
  // (which would infer a latch).
  always_comb begin
    state_d = state_q;
    if (!ctrl_enable) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:  state_d = ST_ARMED;
        ST_ARMED: if (core_sleeping_i)
                    state_d = (cmp_eff == 32'd0) ? ST_FIRE : ST_COUNT;
        ST_COUNT: begin
          if (!core_sleeping_i)
            state_d = ST_ARMED;
          else if (({1'b0, count_q} + 33'd1) >= {1'b0, cmp_eff})
            state_d = ST_FIRE;
        end
        ST_FIRE:  if (!core_sleeping_i)
                    state_d = autoreload ? ST_ARMED : ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------- FSM outputs
  always_comb begin
    fire_set = (state_d == ST_FIRE) && (state_q != ST_FIRE);
    en_clr   = (state_q == ST_FIRE) && (state_d == ST_IDLE);
    wakeup_d = (state_d == ST_FIRE) || (|(event_i & evt_mask));
    count_d  = count_q;
    if (state_d == ST_IDLE || state_d == ST_ARMED)
      count_d = 32'd0;
    else if (state_q == ST_COUNT && count_q != 32'hFFFF_FFFF)
      count_d = count_q + 32'd1;
  end

  // ----------------------------------------------------------------- registers
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      ctrl_enable <= 1'b0;
      ctrl_irq_en <= 1'b0;
      compare_q   <= 32'd0;
      count_q     <= 32'd0;
      evt_mask    <= '0;
      fired_q     <= 1'b0;
      irq_q       <= 1'b0;
      wakeup_q    <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_enable <= PWDATA[0];
        ctrl_irq_en <= PWDATA[1];
      end else if (en_clr) begin
        ctrl_enable <= 1'b0;
      end
      if (wr_compare) compare_q <= PWDATA;
      if (wr_mask)    evt_mask  <= PWDATA[NUM_EVT-1:0];
      // A hardware set in the same cycle as a W1C must not be lost.
      if (fire_set)                    fired_q <= 1'b1;
      else if (wr_status && PWDATA[0]) fired_q <= 1'b0;
      count_q  <= count_d;
      irq_q    <= fired_q & ctrl_irq_en;
      wakeup_q <= wakeup_d;
    end
  end

`ifdef WAKEUP_TIMER_AUTORELOAD_EN
  always_ff @(posedge HCLK) begin
    if (!HRESETn)     autoreload <= 1'b0;
    else if (wr_ctrl) autoreload <= PWDATA[2];
  end
`else
  assign autoreload = 1'b0;
`endif

  // ----------------------------------------------------------------- read mux
  always_comb begin
    rdata = 32'd0;
    unique case (word_idx)
      IDX_CTRL:    rdata = {29'd0, autoreload, ctrl_irq_en, ctrl_enable};
      IDX_COMPARE: rdata = compare_q;
      IDX_COUNT:   rdata = count_q;
      IDX_STATUS:  rdata = {29'd0, state_q, fired_q};
      IDX_MASK:    rdata = 32'(evt_mask);
      default:     rdata = 32'd0;
    endcase
  end

  assign PRDATA      = rd_en ? rdata : 32'd0;
  assign PREADY      = 1'b1;
  assign PSLVERR     = 1'b0;
  assign wakeup_o    = wakeup_q;
  assign timer_irq_o = irq_q;

endmodule

// File: tb/tb_sleep_wakeup_timer.sv
// Directed self-checking bench for sleep_wakeup_timer (APB access, timeout,
// early wake, event path and boundary cases).
module tb_sleep_wakeup_timer;

  localparam logic [11:0] A_CTRL    = 12'h000;
  localparam logic [11:0] A_COMPARE = 12'h004;
  localparam logic [11:0] A_COUNT   = 12'h008;
  localparam logic [11:0] A_STATUS  = 12'h00C;
  localparam logic [11:0] A_MASK    = 12'h010;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE, PSEL, PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [7:0]  event_i;
  logic        core_sleeping_i;
  logic        wakeup_o, timer_irq_o;

  int n_checks = 0;
  int n_pass   = 0;

  sleep_wakeup_timer #(.APB_ADDR_WIDTH(12), .NUM_EVT(8)) dut (
    .HCLK            (HCLK),
    .HRESETn         (HRESETn),
    .PADDR           (PADDR),
    .PWDATA          (PWDATA),
    .PWRITE          (PWRITE),
    .PSEL            (PSEL),
    .PENABLE         (PENABLE),
    .PRDATA          (PRDATA),
    .PREADY          (PREADY),
    .PSLVERR         (PSLVERR),
    .event_i         (event_i),
    .core_sleeping_i (core_sleeping_i),
    .wakeup_o        (wakeup_o),
    .timer_irq_o     (timer_irq_o)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_checks++;
    if (observed === expected) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
  endtask

  // Leaves time 1 ns after a rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  // Write takes effect on the third rising edge after the call; returns 1 ns after it.
  task automatic apb_write(input logic [11:0] addr, input logic [31:0] data);
    @(posedge HCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = addr; PWDATA = data;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    @(posedge HCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] addr, output logic [31:0] data);
    @(posedge HCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = addr;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    #1 data = PRDATA;
    @(posedge HCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [11:0] addr,
                           input logic [31:0] expected);
    logic [31:0] rd;
    apb_read(addr, rd);
    check(tag, rd, expected);
  endtask

  initial begin
    HRESETn = 1'b0;
    core_sleeping_i = 1'b0;
    event_i = 8'hFF;
    // APB write activity while reset is held must be discarded.
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = A_CTRL; PWDATA = 32'hFFFF_FFFF;
    step(1);
    PADDR = A_MASK;
    step(1);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    HRESETn = 1'b1;
    step(1);
    check("rst_wakeup", {31'd0, wakeup_o}, 32'd0);
    check("rst_irq", {31'd0, timer_irq_o}, 32'd0);
    check("rst_prdata_idle", PRDATA, 32'd0);
    check_reg("rst_ctrl", A_CTRL, 32'd0);
    check_reg("rst_compare", A_COMPARE, 32'd0);
    check_reg("rst_count", A_COUNT, 32'd0);
    check_reg("rst_status", A_STATUS, 32'd0);
    check_reg("rst_mask", A_MASK, 32'd0);
    event_i = 8'h00;

    // Unmapped index: write ignored, reads 0.
    apb_write(12'h014, 32'hFFFF_FFFF);
    check_reg("unmapped_5", 12'h014, 32'd0);
    check_reg("unmapped_7", 12'h01C, 32'd0);

    // Timeout, COMPARE=5 with IRQ_EN: core sleep sampled in ARMED two edges after CTRL write.
    apb_write(A_COMPARE, 32'd5);
    apb_write(A_CTRL, 32'h3);
    core_sleeping_i = 1'b1;
    step(6);
    check("to_wake_early", {31'd0, wakeup_o}, 32'd0);
    step(1);
    check("to_wake_on_time", {31'd0, wakeup_o}, 32'd1);
    check_reg("to_status_fire", A_STATUS, 32'h7);
    check("to_irq", {31'd0, timer_irq_o}, 32'd1);
    core_sleeping_i = 1'b0;
    step(1);
    check("to_wake_drop", {31'd0, wakeup_o}, 32'd0);
    check_reg("to_status_idle", A_STATUS, 32'h1);
    check_reg("to_ctrl_oneshot", A_CTRL, 32'h2);
    apb_write(A_STATUS, 32'h1);
    step(1);
    check("to_irq_clear", {31'd0, timer_irq_o}, 32'd0);
    check_reg("to_status_w1c", A_STATUS, 32'h0);
    apb_write(A_CTRL, 32'h0);

    // Early wake: sleep ends before COMPARE=100 is reached.
    apb_write(A_COMPARE, 32'd100);
    apb_write(A_CTRL, 32'h1);
    core_sleeping_i = 1'b1;
    step(10);
    core_sleeping_i = 1'b0;
    step(2);
    check("ew_wakeup", {31'd0, wakeup_o}, 32'd0);
    check_reg("ew_status_armed", A_STATUS, 32'h2);
    check_reg("ew_count", A_COUNT, 32'd0);
    apb_write(A_CTRL, 32'h0);
    step(1);
    check_reg("ew_status_idle", A_STATUS, 32'h0);

    // Event path, independent of ENABLE.
    apb_write(A_MASK, 32'h04);
    check_reg("evt_mask_rb", A_MASK, 32'h04);
    event_i = 8'h02;
    step(2);
    check("evt_unmasked", {31'd0, wakeup_o}, 32'd0);
    event_i = 8'h04;
    step(1);
    check("evt_masked_hi", {31'd0, wakeup_o}, 32'd1);
    event_i = 8'h00;
    step(1);
    check("evt_masked_lo", {31'd0, wakeup_o}, 32'd0);
    apb_write(A_MASK, 32'h0);

    // COMPARE=0 fires straight from ARMED.
    apb_write(A_COMPARE, 32'd0);
    apb_write(A_CTRL, 32'h1);
    core_sleeping_i = 1'b1;
    step(1);
    check("c0_wake_armed", {31'd0, wakeup_o}, 32'd0);
    step(1);
    check("c0_wake_fire", {31'd0, wakeup_o}, 32'd1);
    core_sleeping_i = 1'b0;
    step(1);
    check("c0_wake_drop", {31'd0, wakeup_o}, 32'd0);
    check_reg("c0_status", A_STATUS, 32'h1);
    apb_write(A_STATUS, 32'h1);

    // COMPARE lowered to 10 while COUNT=50: fires at the write edge.
    apb_write(A_COMPARE, 32'd1000);
    apb_write(A_CTRL, 32'h1);
    core_sleeping_i = 1'b1;
    step(50);
    check("cmp_wr_before", {31'd0, wakeup_o}, 32'd0);
    apb_write(A_COMPARE, 32'd10);
    check("cmp_wr_fire", {31'd0, wakeup_o}, 32'd1);
    check_reg("cmp_wr_status", A_STATUS, 32'h7);
    core_sleeping_i = 1'b0;
    step(1);
    apb_write(A_STATUS, 32'h1);
    check_reg("cmp_wr_ctrl", A_CTRL, 32'h0);

    // FIRED W1C landing on the fire edge: set wins.
    apb_write(A_COMPARE, 32'd20);
    apb_write(A_CTRL, 32'h1);
    core_sleeping_i = 1'b1;
    step(19);
    apb_write(A_STATUS, 32'h1);
    check("w1c_race_wake", {31'd0, wakeup_o}, 32'd1);
    check_reg("w1c_race_status", A_STATUS, 32'h7);
    apb_write(A_STATUS, 32'h1);
    check_reg("w1c_after", A_STATUS, 32'h6);
    core_sleeping_i = 1'b0;
    step(1);
    check_reg("w1c_idle", A_STATUS, 32'h0);

    // Software disable mid-COUNT.
    apb_write(A_COMPARE, 32'd100);
    apb_write(A_CTRL, 32'h1);
    core_sleeping_i = 1'b1;
    step(10);
    apb_write(A_CTRL, 32'h0);
    step(2);
    check_reg("dis_status", A_STATUS, 32'h0);
    check_reg("dis_count", A_COUNT, 32'd0);
    check("dis_wakeup", {31'd0, wakeup_o}, 32'd0);
    core_sleeping_i = 1'b0;

`ifdef WAKEUP_TIMER_AUTORELOAD_EN
    // Two sleep periods fire without software rewrite.
    apb_write(A_COMPARE, 32'd5);
    apb_write(A_CTRL, 32'h5);
    core_sleeping_i = 1'b1;
    step(6);
    check("ar1_early", {31'd0, wakeup_o}, 32'd0);
    step(1);
    check("ar1_fire", {31'd0, wakeup_o}, 32'd1);
    core_sleeping_i = 1'b0;
    step(1);
    check("ar1_drop", {31'd0, wakeup_o}, 32'd0);
    check_reg("ar_status_armed", A_STATUS, 32'h3);
    check_reg("ar_ctrl_kept", A_CTRL, 32'h5);
    core_sleeping_i = 1'b1;
    step(5);
    check("ar2_early", {31'd0, wakeup_o}, 32'd0);
    step(1);
    check("ar2_fire", {31'd0, wakeup_o}, 32'd1);
    core_sleeping_i = 1'b0;
    apb_write(A_CTRL, 32'h0);
`else
    apb_write(A_CTRL, 32'h4);
    check_reg("ar_bit_absent", A_CTRL, 32'h0);
    apb_write(A_CTRL, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
